// File: rtl/serial_frame_tx_if.sv
// Word handshake plus serial-line bundle between a producer and serial_frame_tx.
interface serial_frame_tx_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] dado;
  logic             valido;
  logic             pronto;
  logic             saida;
  logic             ativo;
  logic             fim;

  modport master (
    output dado, output valido,
    input  pronto, input saida, input ativo, input fim
  );

  modport slave (
    input  dado, input valido,
    output pronto, output saida, output ativo, output fim
  );
endinterface

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: preamble then data word MSB first, one bit per clock,
// with a one-cycle idle gap between frames. All outputs are registered Moore outputs.
module serial_frame_tx #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned PRE_LEN  = 4,
  parameter logic [7:0]  PREAMBLE = 8'b0000_1010,
  parameter logic        IDLE_BIT = 1'b0
) (
  input logic              clk,
  input logic              rst,
  serial_frame_tx_if.slave bus
);
  localparam int unsigned MAX_LEN = (WIDTH > PRE_LEN) ? WIDTH : PRE_LEN;
  localparam int unsigned CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [MAX_LEN-1:0] PRE_EXT = MAX_LEN'(PREAMBLE);

  typedef enum logic [1:0] {
    OCIOSO    = 2'd0,
    PREAMB    = 2'd1,
    DADOS     = 2'd2,
    INTERVALO = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   word_q, word_d;
  logic               saida_q, saida_d;
  logic               ativo_q, ativo_d;
  logic               fim_q, fim_d;
  logic               pronto_q, pronto_d;
  logic               accept;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    accept  = bus.valido & pronto_q;

    case (state_q)
      // The gap state lasts one cycle; without a new word both fall back to idle.
      OCIOSO, INTERVALO: begin
        state_d = OCIOSO;
        if (accept) begin
          word_d  = bus.dado;
          cnt_d   = CNT_W'(PRE_LEN - 1);
          state_d = PREAMB;
        end
      end
      PREAMB: begin
        if (cnt_q == '0) begin
          state_d = DADOS;
          cnt_d   = CNT_W'(WIDTH - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DADOS: begin
        if (cnt_q == '0) begin
          state_d = INTERVALO;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = OCIOSO;
        cnt_d   = '0;
        word_d  = '0;
      end
    endcase

    // Outputs are decoded from the next state so they appear in the same cycle as it.
    saida_d  = IDLE_BIT;
    ativo_d  = 1'b0;
    fim_d    = 1'b0;
    pronto_d = 1'b0;
    case (state_d)
      PREAMB: begin
        saida_d = PRE_EXT[cnt_d];
        ativo_d = 1'b1;
      end
      DADOS: begin
        saida_d = word_d[cnt_d];
        ativo_d = 1'b1;
        fim_d   = (cnt_d == '0);
      end
      default: pronto_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= OCIOSO;
      cnt_q    <= '0;
      word_q   <= '0;
      saida_q  <= IDLE_BIT;
      ativo_q  <= 1'b0;
      fim_q    <= 1'b0;
      pronto_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      word_q   <= word_d;
      saida_q  <= saida_d;
      ativo_q  <= ativo_d;
      fim_q    <= fim_d;
      pronto_q <= pronto_d;
    end
  end

  assign bus.saida  = saida_q;
  assign bus.ativo  = ativo_q;
  assign bus.fim    = fim_q;
  assign bus.pronto = pronto_q;
endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: directed and random frames against a queue-of-cycles model.
module tb_serial_frame_tx;
  localparam int unsigned W  = 8;
  localparam int unsigned PL = 4;
  localparam logic [7:0]  PRE = 8'b0000_1010;

  typedef struct packed {
    logic saida;
    logic ativo;
    logic fim;
    logic pronto;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_frame_tx_if #(.WIDTH(8)) bus ();
  serial_frame_tx_if #(.WIDTH(3)) sbus ();

  serial_frame_tx #(.WIDTH(8), .PRE_LEN(4), .PREAMBLE(8'b0000_1010), .IDLE_BIT(1'b0)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  serial_frame_tx #(.WIDTH(3), .PRE_LEN(2), .PREAMBLE(8'b0000_0011), .IDLE_BIT(1'b0)) dut_s (
    .clk(clk), .rst(rst), .bus(sbus)
  );

  int   checks = 0;
  int   errors = 0;
  int   frames = 0;
  obs_t exp_q[$];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected line content per cycle; an empty queue means the line is idle.
  function automatic obs_t model_now();
    obs_t o;
    if (exp_q.size() == 0) o = 4'b0001;
    else                   o = exp_q[0];
    return o;
  endfunction

  task automatic push_frame(input logic [W-1:0] word);
    obs_t o;
    for (int i = 0; i < int'(PL); i++) begin
      o = '{saida: PRE[PL-1-i], ativo: 1'b1, fim: 1'b0, pronto: 1'b0};
      exp_q.push_back(o);
    end
    for (int i = 0; i < int'(W); i++) begin
      o = '{saida: word[W-1-i], ativo: 1'b1, fim: (i == int'(W) - 1), pronto: 1'b0};
      exp_q.push_back(o);
    end
    o = '{saida: 1'b0, ativo: 1'b0, fim: 1'b0, pronto: 1'b1};
    exp_q.push_back(o);
  endtask

  function automatic logic [3:0] dut_obs();
    return {bus.saida, bus.ativo, bus.fim, bus.pronto};
  endfunction

  task automatic tick(input string tag);
    logic acc;
    obs_t cur;
    cur = model_now();
    acc = rst && bus.valido && cur.pronto;
    @(posedge clk);
    if (!rst) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      if (acc) begin
        push_frame(bus.dado);
        frames++;
      end
    end
    #1;
    cur = model_now();
    chk(tag, 16'(dut_obs()), 16'(cur));
  endtask

  initial begin
    logic [12:0] line_v, fim_v;
    logic [7:0]  cap;
    logic [3:0]  s_exp [6];
    int          act_cnt, start, cyc;
    obs_t        m;

    rst = 1'b0;
    bus.valido = 1'b0;  bus.dado = '0;
    sbus.valido = 1'b0; sbus.dado = '0;

    // Reset state
    tick("reset");
    chk("s_reset", 16'({sbus.saida, sbus.ativo, sbus.fim, sbus.pronto}), 16'h1);
    tick("reset_hold");
    rst = 1'b1;
    tick("idle_after_reset");

    // Single frame of 8'hA5
    bus.dado = 8'hA5; bus.valido = 1'b1;
    tick("a5_accept");
    line_v = {12'b0, bus.saida}; fim_v = {12'b0, bus.fim}; act_cnt = int'(bus.ativo);
    bus.valido = 1'b0; bus.dado = $urandom;
    for (int i = 0; i < 12; i++) begin
      tick("a5_frame");
      line_v = {line_v[11:0], bus.saida};
      fim_v  = {fim_v[11:0], bus.fim};
      act_cnt += int'(bus.ativo);
    end
    chk("a5_line", 16'(line_v), 16'(13'b1010_10100101_0));
    chk("a5_fim", 16'(fim_v), 16'(13'b0000_00000001_0));
    chk("a5_ativo_cycles", 16'(act_cnt), 16'd12);

    // Reset asserted in the middle of the data bits
    bus.dado = $urandom; bus.valido = 1'b1;
    tick("rst_frame_accept");
    bus.valido = 1'b0;
    for (int i = 0; i < 6; i++) tick("rst_frame");
    #2 rst = 1'b0;
    #1 chk("rst_mid_dados", 16'(dut_obs()), 16'h1);
    exp_q.delete();
    tick("rst_low");
    rst = 1'b1;
    for (int i = 0; i < 3; i++) tick("rst_release_idle");

    // Back-to-back: FF then 00 with valido held high
    bus.dado = 8'hFF; bus.valido = 1'b1;
    tick("b2b_accept_ff");
    bus.dado = 8'h00;
    for (int i = 0; i < 13; i++) tick("b2b_ff");
    chk("b2b_second_started", 16'(frames), 16'd4);
    bus.valido = 1'b0;
    for (int i = 0; i < 14; i++) tick("b2b_00");

    // Input changes during a frame are ignored
    bus.dado = 8'hC3; bus.valido = 1'b1;
    tick("c3_accept");
    cap = '0;
    for (int i = 1; i < 12; i++) begin
      bus.dado = 8'h3C; bus.valido = 1'($urandom);
      tick("c3_frame");
      if (i >= int'(PL)) cap = {cap[6:0], bus.saida};
    end
    bus.valido = 1'b0;
    for (int i = 0; i < 3; i++) tick("c3_tail");
    chk("c3_word", 16'(cap), 16'hC3);

    // Small configuration: WIDTH=3, PRE_LEN=2, PREAMBLE=11, word 010
    s_exp[0] = 4'b1100; s_exp[1] = 4'b1100; s_exp[2] = 4'b0100;
    s_exp[3] = 4'b1100; s_exp[4] = 4'b0110; s_exp[5] = 4'b0001;
    sbus.dado = 3'b010; sbus.valido = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      sbus.valido = 1'b0; sbus.dado = 3'($urandom);
      chk("small_cfg", 16'({sbus.saida, sbus.ativo, sbus.fim, sbus.pronto}), 16'(s_exp[i]));
    end

    // Random traffic: 200 frames with random valido duty and data
    start = frames; cyc = 0;
    while ((frames - start) < 200 && cyc < 20000) begin
      bus.valido = ($urandom_range(0, 3) != 0);
      bus.dado   = 8'($urandom);
      tick("rand");
      cyc++;
    end
    chk("rand_frames", 16'(frames - start), 16'd200);
    bus.valido = 1'b0;
    for (int i = 0; i < 14; i++) tick("rand_drain");
    m = model_now();
    chk("drained_idle", 16'(dut_obs()), 16'(m));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
